fpga_reset_seq: RTL and testbench
=================================

Name: fpga_reset_seq

Overview:
Parametrised successor to the single-output FPGA reset generator. Produces N_CHANNELS active-low reset outputs in one clock domain from a PLL-lock style qualifier. All outputs assert together; they release in ascending index order with a programmable gap between channels. Also supports a whole-system software reset and per-channel soft resets. Sits between the PLL/lock logic and the SoC, debug and peripheral reset inputs of FPGA top levels.

Parameters:
N_CHANNELS, 3, number of reset outputs (1..16); released in order 0 first.
SHIFT, 3, hold time in ASSERT and per-channel soft-reset stretch = 2^SHIFT cycles (1..16).
GAP_CYCLES, 2, extra cycles between consecutive channel releases (0..255).
SYNC_STAGES, 2, synchroniser depth for force_rst_n (2..4).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low; all state to reset values.
force_rst_n  in  1  asynchronous qualifier (e.g. PLL locked); low forces full reset.
sw_rst_req  in  1  synchronous one-cycle pulse; restarts the full sequence.
chan_rst_req  in  N_CHANNELS  synchronous per-channel soft-reset request pulses.
rst_n_out  out  N_CHANNELS  active-low resets, registered, glitch-free.
all_released  out  1  high when state is RUN and no channel is in soft reset.
busy  out  1  high in ASSERT or RELEASE.

Behaviour:
- Reset values while rst_n low: rst_n_out = all 0, all_released = 0, busy = 1, state = ASSERT, counters = 0, synchroniser = 0.
- force_ok is force_rst_n passed through SYNC_STAGES flops (plain flops, reset to 0).
- ASSERT state:
  - rst_n_out all 0.
  - 16-bit-wide-enough counter increments each cycle force_ok = 1; clears when force_ok = 0 or sw_rst_req = 1.
  - On the edge where counter == 2^SHIFT-1, force_ok = 1 and sw_rst_req = 0: go to RELEASE, idx = 0, rst_n_out[0] goes to 1.
- RELEASE state:
  - Gap counter counts GAP_CYCLES+1 edges. Channel k releases exactly (GAP_CYCLES+1)·k edges after channel 0.
  - On the edge that releases channel N_CHANNELS-1: go to RUN and set all_released = 1.
  - If N_CHANNELS = 1: ASSERT goes directly to RUN.
- RUN state: chan_rst_req[k] = 1 drives rst_n_out[k] to 0 on the next edge and holds it for 2^SHIFT cycles, then to 1.
  - A re-request during the stretch restarts the stretch count.
  - Simultaneous requests on several channels are independent.
  - all_released = 0 while any stretch is active.
- chan_rst_req is ignored in ASSERT and RELEASE.
- force_ok = 0 in any state: next edge goes to ASSERT, all rst_n_out = 0, all counters and stretches cleared.
- sw_rst_req = 1 in any state: same effect as force_ok = 0 for that edge.
- sw_rst_req has priority over chan_rst_req on the same edge.
- rst_n asserted mid-sequence: immediate asynchronous return to reset values.
- Outputs change only on clk edges, apart from the asynchronous assertion on rst_n.

Decomposition:
- Shared package fpga_reset_pkg holds:
  - state encoding localparams ST_ASSERT, ST_RELEASE, ST_RUN (2-bit);
  - a function computing counter width from SHIFT and GAP_CYCLES.
- One sub-module, reset_stretch: a per-channel soft-reset stretcher (req in, active out, 2^SHIFT down-counter, clear input). It is instantiated N_CHANNELS times via generate.

Test Plan:
1. N=3, SHIFT=3, GAP=2, SYNC=2. force_rst_n high throughout; rst_n released before edge 1. -> rst_n_out[0] rises after edge 10, [1] after edge 13, [2] after edge 16; all_released = 1 and busy = 0 after edge 16.
2. force_rst_n low for 1 cycle at edge 14 (channels 0,1 released). -> all rst_n_out = 0 by edge 17; sequence restarts; channel 0 rises 8 edges after force_ok returns to 1.
3. In RUN, chan_rst_req = 3'b010 for one cycle. -> rst_n_out[1] = 0 for exactly 8 cycles; [0] and [2] stay 1; all_released = 0 for those 8 cycles.
4. In RUN, sw_rst_req pulse together with chan_rst_req[0]. -> all outputs 0 next edge; full sequence replays with the same timing as test 1, counted from the pulse.
5. chan_rst_req[2] pulsed during RELEASE. -> ignored; rst_n_out[2] releases on schedule and stays 1.
6. rst_n asserted mid-RELEASE. -> rst_n_out = 0 asynchronously, before the next edge; busy = 1.

Source files
------------

// File: rtl/fpga_reset_pkg.sv
// Shared encodings and sizing helpers for the multi-channel FPGA reset sequencer.
// Pure declarations: no latency, no flow control.
package fpga_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Wide enough to hold 2^shift (stretch load value) and gap (release spacing).
  function automatic int cnt_width(input int shift, input int gap);
    int span;
    span = 1 << shift;
    if (gap + 1 > span) span = gap + 1;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/fpga_reset_seq_if.sv
// Control/status bundle of the reset sequencer: software requests in, reset outputs out.
// Plain wires: no latency, no backpressure.
interface fpga_reset_seq_if #(
  parameter int N_CHANNELS = 3
);

  logic                  sw_rst_req;
  logic [N_CHANNELS-1:0] chan_rst_req;
  logic [N_CHANNELS-1:0] rst_n_out;
  logic                  all_released;
  logic                  busy;

  modport master (
    output sw_rst_req, chan_rst_req,
    input  rst_n_out, all_released, busy
  );

  modport slave (
    input  sw_rst_req, chan_rst_req,
    output rst_n_out, all_released, busy
  );

endinterface

// File: rtl/reset_stretch.sv
// Per-channel soft-reset stretcher: active for 2^SHIFT cycles after the last req, one-cycle latency.
// No backpressure; clr wins over req and zeroes the count.
module reset_stretch
  import fpga_reset_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  output logic active,
  output logic active_nxt
);

  localparam int SW = cnt_width(SHIFT, 0);
  localparam logic [SW-1:0] STRETCH = SW'(1 << SHIFT);

  logic [SW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (req) begin
      cnt_d = STRETCH;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
    end
    active_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active     = active_q;
  assign active_nxt = active_d;

endmodule

// File: rtl/fpga_reset_seq.sv
// Multi-channel reset sequencer: all outputs assert together, release in index order GAP_CYCLES+1 apart.
// Outputs registered (one edge after the cause, async assert on rst_n); no backpressure.
module fpga_reset_seq
  import fpga_reset_pkg::*;
#(
  parameter int N_CHANNELS  = 3,
  parameter int SHIFT       = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             force_rst_n,
  fpga_reset_seq_if.slave  bus
);

  localparam int CW = cnt_width(SHIFT, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'((1 << SHIFT) - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_CHANNELS-1:0]   rst_n_out_q, rst_n_out_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    force_ok;
  logic                    restart;
  logic [N_CHANNELS-1:0]   rel_next;
  logic [N_CHANNELS-1:0]   soft_req, soft_act, soft_act_nxt;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], force_rst_n};
  assign force_ok = sync_q[SYNC_STAGES-1];
  assign restart  = ~force_ok | bus.sw_rst_req;

  // Released channels form a thermometer code, so the next release is a shift-in of a 1.
  assign rel_next = N_CHANNELS'({rst_n_out_q, 1'b1});
  assign soft_req = (state_q == ST_RUN) ? bus.chan_rst_req : '0;

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_stretch
    reset_stretch #(
      .SHIFT (SHIFT)
    ) u_stretch (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (soft_req[k]),
      .clr        (restart),
      .active     (soft_act[k]),
      .active_nxt (soft_act_nxt[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_n_out_d = rst_n_out_q;
    if (restart) begin
      state_d     = ST_ASSERT;
      cnt_d       = '0;
      rst_n_out_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_out_d = '0;
          if (cnt_q == HOLD_LAST) begin
            cnt_d       = '0;
            rst_n_out_d = N_CHANNELS'(1);
            state_d     = (N_CHANNELS == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d       = '0;
            rst_n_out_d = rel_next;
            if (&rel_next) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          rst_n_out_d = ~soft_act_nxt;
        end
        default: begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          rst_n_out_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      rst_n_out_q <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_n_out_q <= rst_n_out_d;
      sync_q      <= sync_d;
    end
  end

  assign bus.rst_n_out    = rst_n_out_q;
  assign bus.busy         = (state_q != ST_RUN);
  assign bus.all_released = (state_q == ST_RUN) && ~|soft_act;

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Bench for fpga_reset_seq: directed scenarios plus random traffic against an edge-number timeline model.
module tb_fpga_reset_seq;

  localparam int N     = 3;
  localparam int SHIFT = 3;
  localparam int GAP   = 2;
  localparam int SYNC  = 2;
  localparam int HOLD  = 1 << SHIFT;

  logic clk = 1'b0;
  logic rst_n;
  logic force_rst_n;

  fpga_reset_seq_if #(.N_CHANNELS(N)) bus ();

  fpga_reset_seq #(
    .N_CHANNELS  (N),
    .SHIFT       (SHIFT),
    .GAP_CYCLES  (GAP),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .force_rst_n (force_rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Timeline model: e = edges since rst_n release, R = last edge that restarted the sequence,
  // channel k rises at R + HOLD + (GAP+1)*k, soft resets hold a channel low until low_until[k].
  int e;
  int R;
  int low_until [N];
  bit hist [0:16383];

  function automatic int rel_edge(input int k);
    return R + HOLD + (GAP + 1) * k;
  endfunction

  function automatic logic [N+1:0] exp_vec();
    logic [N-1:0] o;
    logic b, a;
    b = (e < rel_edge(N - 1));
    a = !b;
    for (int k = 0; k < N; k++) begin
      o[k] = (e >= rel_edge(k)) && (e >= low_until[k]);
      if (e < low_until[k]) a = 1'b0;
    end
    return {o, a, b};
  endfunction

  function automatic logic [N+1:0] obs_vec();
    return {bus.rst_n_out, bus.all_released, bus.busy};
  endfunction

  task automatic model_reset();
    e = 0;
    R = 0;
    foreach (low_until[k]) low_until[k] = 0;
  endtask

  task automatic step();
    bit fok, in_run;
    @(posedge clk);
    e++;
    hist[e] = force_rst_n;
    fok     = (e > SYNC) ? hist[e - SYNC] : 1'b0;
    in_run  = (e - 1) >= rel_edge(N - 1);
    if (!fok || bus.sw_rst_req) begin
      R = e;
      foreach (low_until[k]) low_until[k] = 0;
    end else if (in_run) begin
      for (int k = 0; k < N; k++)
        if (bus.chan_rst_req[k]) low_until[k] = e + HOLD;
    end
    @(negedge clk);
  endtask

  task automatic hard_reset();
    #2;
    rst_n            = 1'b0;
    force_rst_n      = 1'b1;
    bus.sw_rst_req   = 1'b0;
    bus.chan_rst_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_to_run();
    while (e <= rel_edge(N - 1)) step();
  endtask

  task automatic test_reset();
    logic [N+1:0] obs;
    rst_n            = 1'b1;
    force_rst_n      = 1'b1;
    bus.sw_rst_req   = 1'b0;
    bus.chan_rst_req = '0;
    #1 rst_n = 1'b0;
    #1;
    obs = obs_vec();
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs, 5'b00001);
    end
    repeat (2) @(negedge clk);
    obs = obs_vec();
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", obs, 5'b00001);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_power_up();
    int           se [6] = '{9, 10, 12, 13, 15, 16};
    logic [N+1:0] sv [6] = '{5'b00001, 5'b00101, 5'b00101, 5'b01101, 5'b01101, 5'b11110};
    logic [N+1:0] obs;
    for (int i = 0; i < 20; i++) begin
      step();
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL power_up edge %0d: got %b want %b", e, obs, exp_vec());
      end
      for (int j = 0; j < 6; j++) begin
        if (e == se[j]) begin
          n_cmp++;
          if (obs !== sv[j]) begin
            n_err++;
            $display("FAIL power_up_fixed edge %0d: got %b want %b", e, obs, sv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_force_glitch();
    int           se [4] = '{15, 17, 23, 24};
    logic [N+1:0] sv [4] = '{5'b01101, 5'b00001, 5'b00001, 5'b00101};
    logic [N+1:0] obs;
    hard_reset();
    for (int i = 0; i < 32; i++) begin
      force_rst_n = (e == 13) ? 1'b0 : 1'b1;
      step();
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL force_glitch edge %0d: got %b want %b", e, obs, exp_vec());
      end
      for (int j = 0; j < 4; j++) begin
        if (e == se[j]) begin
          n_cmp++;
          if (obs !== sv[j]) begin
            n_err++;
            $display("FAIL force_glitch_fixed edge %0d: got %b want %b", e, obs, sv[j]);
          end
        end
      end
    end
    force_rst_n = 1'b1;
  endtask

  task automatic test_chan_soft();
    logic [N-1:0] mask;
    logic [N+1:0] obs;
    int           lowc [N];
    run_to_run();
    for (int m = 0; m < 4; m++) begin
      mask = (m == 0) ? 3'b010 : 3'($urandom_range(1, 7));
      foreach (lowc[k]) lowc[k] = 0;
      bus.chan_rst_req = mask;
      step();
      bus.chan_rst_req = '0;
      for (int i = 0; i < 12; i++) begin
        if (i > 0) step();
        obs = obs_vec();
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_err++;
          $display("FAIL chan_soft mask %b edge %0d: got %b want %b", mask, e, obs, exp_vec());
        end
        for (int k = 0; k < N; k++) if (!bus.rst_n_out[k]) lowc[k]++;
      end
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (lowc[k] != (mask[k] ? HOLD : 0)) begin
          n_err++;
          $display("FAIL chan_soft_len ch%0d mask %b: got %0d low cycles want %0d",
                   k, mask, lowc[k], mask[k] ? HOLD : 0);
        end
      end
    end
  endtask

  task automatic test_rerequest();
    int           d, lowc;
    logic [N+1:0] obs;
    run_to_run();
    d    = $urandom_range(1, 6);
    lowc = 0;
    bus.chan_rst_req = 3'b100;
    step();
    bus.chan_rst_req = '0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        if (i == d) bus.chan_rst_req = 3'b100;
        step();
        bus.chan_rst_req = '0;
      end
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL rerequest edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (!bus.rst_n_out[2]) lowc++;
    end
    n_cmp++;
    if (lowc != d + HOLD) begin
      n_err++;
      $display("FAIL rerequest_len: got %0d low cycles want %0d", lowc, d + HOLD);
    end
  endtask

  task automatic test_sw_rst();
    int           p;
    int           so [4] = '{7, 8, 11, 14};
    logic [N+1:0] sv [4] = '{5'b00001, 5'b00101, 5'b01101, 5'b11110};
    logic [N+1:0] obs;
    run_to_run();
    bus.sw_rst_req   = 1'b1;
    bus.chan_rst_req = 3'b001;
    step();
    bus.sw_rst_req   = 1'b0;
    bus.chan_rst_req = '0;
    p   = e;
    obs = obs_vec();
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_err++;
      $display("FAIL sw_rst_next: got %b want %b", obs, 5'b00001);
    end
    for (int i = 0; i < 18; i++) begin
      step();
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL sw_rst edge %0d: got %b want %b", e, obs, exp_vec());
      end
      for (int j = 0; j < 4; j++) begin
        if (e == p + so[j]) begin
          n_cmp++;
          if (obs !== sv[j]) begin
            n_err++;
            $display("FAIL sw_rst_fixed +%0d: got %b want %b", so[j], obs, sv[j]);
          end
        end
      end
    end
  endtask

  task automatic test_chan_in_release();
    int           t, lowc;
    logic [N+1:0] obs;
    hard_reset();
    t    = $urandom_range(11, 16);
    lowc = 0;
    for (int i = 0; i < 30; i++) begin
      bus.chan_rst_req = (e + 1 == t) ? 3'b100 : 3'b000;
      step();
      bus.chan_rst_req = '0;
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL chan_in_release edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e >= 16 && !bus.rst_n_out[2]) lowc++;
    end
    n_cmp++;
    if (lowc != 0) begin
      n_err++;
      $display("FAIL chan_in_release_ignored: got %0d low cycles want 0", lowc);
    end
  endtask

  task automatic test_async_reset();
    int           stop;
    logic [N+1:0] obs;
    hard_reset();
    stop = $urandom_range(11, 15);
    while (e < stop) step();
    #2 rst_n = 1'b0;
    #1;
    obs = obs_vec();
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_err++;
      $display("FAIL async_reset edge %0d: got %b want %b", e, obs, 5'b00001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      step();
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL async_reset_replay edge %0d: got %b want %b", e, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [N+1:0] obs;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      force_rst_n      = ($urandom_range(0, 39) != 0);
      bus.sw_rst_req   = ($urandom_range(0, 59) == 0);
      bus.chan_rst_req = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step();
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL random edge %0d: got %b want %b", e, obs, exp_vec());
      end
    end
    force_rst_n      = 1'b1;
    bus.sw_rst_req   = 1'b0;
    bus.chan_rst_req = '0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_force_glitch();
    test_chan_soft();
    test_rerequest();
    test_sw_rst();
    test_chan_in_release();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
